// File: rtl/crc_pkg.sv
// Shared CRC definitions for the serial FEC link blocks.
//   state_t   : receive checker frame FSM states
//   crc_step  : one bit-serial CRC update (MSB-first, implicit top term)
package crc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Advances a CRC register of 'width' bits (1..32) by one input bit.
    // crc and poly are right-aligned; poly omits the implicit top term.
    function automatic logic [31:0] crc_step(input logic [31:0] crc,
                                             input logic        b,
                                             input logic [31:0] poly,
                                             input int          width);
        logic        fb;
        logic [31:0] nxt;
        logic [31:0] mask;
        fb   = b ^ crc[width-1];
        nxt  = crc << 1;
        if (fb) begin
            nxt = nxt ^ poly;
        end
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return nxt & mask;
    endfunction

endpackage

// File: rtl/crc_serial_lfsr.sv
// CRC remainder register for the serial checker.
//   clk, rst_n : clock, asynchronous active-low reset (register -> SEED)
//   load       : use SEED instead of the held value as the base for this step
//   en         : advance the register by one bit
//   bit_in     : serial bit folded in when en=1
//   crc        : current remainder
//   zero       : the remainder after folding in bit_in (from load/crc base) is zero
module crc_serial_lfsr
    import crc_pkg::*;
#(
    parameter int                 CRC_WIDTH = 4,
    parameter logic [CRC_WIDTH:0] POLY      = 5'b10011,
    parameter logic [CRC_WIDTH-1:0] SEED    = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc,
    output logic                 zero
);

    logic [CRC_WIDTH-1:0] base;
    logic [CRC_WIDTH-1:0] crc_next;

    assign base     = load ? SEED : crc;
    assign crc_next = CRC_WIDTH'(crc_step(32'(base), bit_in,
                                          32'(POLY[CRC_WIDTH-1:0]), CRC_WIDTH));
    assign zero     = (crc_next == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= SEED;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/crc_serial_checker.sv
// Receive-side serial CRC checker: collects DATA_WIDTH payload bits and
// CRC_WIDTH CRC bits MSB first, then presents the payload with a pass flag.
//   clk, rst_n      : clock, asynchronous active-low reset
//   s_valid/s_ready : serial bit handshake; s_sof marks bit 0 of a frame, s_bit is the bit
//   m_valid/m_ready : result handshake; m_data payload, m_crc_ok remainder-zero flag
//   abort           : 1-cycle pulse when s_sof restarts an unfinished frame
//   err_cnt         : saturating count of results with m_crc_ok=0
//   dbg_state       : current FSM state
//   dbg_crc         : current CRC remainder
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1; valid, once raised, holds with its payload until that edge.
module crc_serial_checker
    import crc_pkg::*;
#(
    parameter int                   DATA_WIDTH = 12,
    parameter int                   CRC_WIDTH  = 4,
    parameter logic [CRC_WIDTH:0]   POLY       = 5'b10011,
    parameter logic [CRC_WIDTH-1:0] SEED       = '0,
    parameter int                   ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_sof,
    input  logic                  s_bit,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_crc_ok,
    output logic                  abort,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output state_t                dbg_state,
    output logic [CRC_WIDTH-1:0]  dbg_crc
);

    localparam int CNT_W = $clog2(DATA_WIDTH + CRC_WIDTH + 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(DATA_WIDTH + CRC_WIDTH);
    // A frame of one data bit goes straight from its first bit into the CRC phase.
    localparam state_t FIRST_STATE = (DATA_WIDTH == 1) ? S_CRC : S_DATA;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [DATA_WIDTH-1:0] data_sr;
    logic                  beat;
    logic                  lfsr_load;
    logic                  lfsr_en;
    logic                  rem_zero;

    assign beat    = s_valid && s_ready;
    assign cnt_inc = cnt + 1'b1;
    // s_sof restarts from SEED in every accepting state; in S_IDLE only s_sof beats count.
    assign lfsr_load = beat && s_sof;
    assign lfsr_en   = beat && (s_sof || (state != S_IDLE));

    assign dbg_state = state;

    crc_serial_lfsr #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLY      (POLY),
        .SEED      (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (lfsr_load),
        .en     (lfsr_en),
        .bit_in (s_bit),
        .crc    (dbg_crc),
        .zero   (rem_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            data_sr  <= '0;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_crc_ok <= 1'b0;
            abort    <= 1'b0;
            err_cnt  <= '0;
        end else begin
            abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (beat && s_sof) begin
                        cnt     <= CNT_W'(1);
                        data_sr <= DATA_WIDTH'(s_bit);
                        state   <= FIRST_STATE;
                    end
                end
                S_DATA, S_CRC: begin
                    if (beat) begin
                        if (s_sof) begin
                            // Partial frame is dropped; this bit is data bit 0 of a new frame.
                            abort   <= 1'b1;
                            cnt     <= CNT_W'(1);
                            data_sr <= DATA_WIDTH'(s_bit);
                            state   <= FIRST_STATE;
                        end else begin
                            cnt <= cnt_inc;
                            if (state == S_DATA) begin
                                data_sr <= (data_sr << 1) | DATA_WIDTH'(s_bit);
                                if (cnt_inc == DATA_LAST) begin
                                    state <= S_CRC;
                                end
                            end else if (cnt_inc == FRAME_LAST) begin
                                state    <= S_OUT;
                                s_ready  <= 1'b0;
                                m_valid  <= 1'b1;
                                m_data   <= data_sr;
                                m_crc_ok <= rem_zero;
                                if (!rem_zero && (err_cnt != {ERR_CNT_W{1'b1}})) begin
                                    err_cnt <= err_cnt + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        state   <= S_IDLE;
                        s_ready <= 1'b1;
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_serial_checker.sv
// Self-checking bench for crc_serial_checker (default parameters).
module tb_crc_serial_checker;
    import crc_pkg::*;

    localparam int DW = 12;
    localparam int CW = 4;
    localparam int EW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic          s_sof;
    logic          s_bit;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_crc_ok;
    logic          abort;
    logic [EW-1:0] err_cnt;
    state_t        dbg_state;
    logic [CW-1:0] dbg_crc;

    crc_serial_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_bit     (s_bit),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_crc_ok  (m_crc_ok),
        .abort     (abort),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state),
        .dbg_crc   (dbg_crc)
    );

    // m_ready: 0 = hold off, 1 = always ready, 2 = random
    int rdy_mode = 1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;
    int abort_seen = 0;
    logic [EW+DW:0] exp_q[$];   // {err_cnt, crc_ok, data}
    logic [EW-1:0]  exp_err = '0;
    logic [EW+DW:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: CRC as the GF(2) remainder of the frame polynomial by x^4+x+1.
    function automatic logic [CW-1:0] gf2_rem(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 15; i >= CW; i--) begin
            if (r[i]) r = r ^ (16'h0013 << (i - CW));
        end
        return r[CW-1:0];
    endfunction

    function automatic logic [15:0] make_frame(input logic [DW-1:0] d);
        return {d, gf2_rem({d, 4'h0})};
    endfunction

    task automatic push_exp(input logic [DW-1:0] d, input logic ok);
        if (!ok && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
        exp_q.push_back({exp_err, ok, d});
    endtask

    always @(negedge clk) begin
        if (abort === 1'b1) abort_seen++;
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got data 0x%0h, want no result", m_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_data", 32'(m_data), 32'(mon_e[DW-1:0]));
                check("result_crc_ok", 32'(m_crc_ok), 32'(mon_e[DW]));
                check("result_err_cnt", 32'(err_cnt), 32'(mon_e[EW+DW:DW+1]));
            end
        end
    end

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic beat(input logic sof, input logic b, input int gap);
        int  n;
        bit  got;
        s_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_sof   = sof;
        s_bit   = b;
        n   = 0;
        got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (s_ready) got = 1;
            else n++;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL beat_timeout: got s_ready=0 for %0d cycles, want 1", n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] f, input int gapmax);
        for (int i = 0; i < 16; i++) beat(i == 0, f[15-i], $urandom_range(0, gapmax));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", 32'(n < 400), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_crc_ok"}, 32'(m_crc_ok), 32'd0);
        check({tag, "_abort"}, 32'(abort), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
        check({tag, "_crc"}, 32'(dbg_crc), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0]   frame;
        logic [DW-1:0] exp_data;
        logic          exp_ok;
        logic [EW-1:0] exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [15:0]   f;
        logic [15:0]   junk;
        logic [DW-1:0] d;
        int            a0;
        int            guard;

        vecs[0] = '{16'h0013, 12'h001, 1'b1, 8'd0};
        vecs[1] = '{16'h0012, 12'h001, 1'b0, 8'd1};
        vecs[2] = '{16'h0023, 12'h002, 1'b0, 8'd2};
        vecs[3] = '{16'h0026, 12'h002, 1'b1, 8'd2};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_bit   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Table vectors: good / corrupted frames, latency and error count.
        for (int v = 0; v < 4; v++) begin
            f = vecs[v].frame;
            exp_err = vecs[v].exp_err;
            exp_q.push_back({vecs[v].exp_err, vecs[v].exp_ok, vecs[v].exp_data});
            for (int i = 0; i < 15; i++) beat(i == 0, f[15-i], 0);
            check("latency_before_last", 32'(m_valid), 32'd0);
            beat(1'b0, f[0], 0);
            check("latency_valid_next", 32'(m_valid), 32'd1);
            check("vec_err_cnt", 32'(err_cnt), 32'(vecs[v].exp_err));
            wait_drain();
        end

        // Backpressure: result holds, no bits taken while m_ready=0.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        push_exp(12'h002, 1'b1);
        send_frame(16'h0026, 0);
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_bit   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_m_valid", 32'(m_valid), 32'd1);
            check("bp_s_ready", 32'(s_ready), 32'd0);
            check("bp_state", 32'(dbg_state), 32'(S_OUT));
            check("bp_m_data", 32'(m_data), 32'h002);
        end
        s_valid  = 1'b0;
        s_sof    = 1'b0;
        rdy_mode = 1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("bp_release_s_ready", 32'(s_ready), 32'd1);
        check("bp_release_m_valid", 32'(m_valid), 32'd0);
        check("bp_release_state", 32'(dbg_state), 32'(S_IDLE));
        check("bp_hold_m_data", 32'(m_data), 32'h002);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Restart by s_sof at bit 7.
        a0   = abort_seen;
        junk = 16'h5A3C;
        f    = 16'h0013;
        push_exp(12'h001, 1'b1);
        for (int i = 0; i < 7; i++) beat(i == 0, junk[15-i], 0);
        beat(1'b1, f[15], 0);
        check("abort_pulse", 32'(abort), 32'd1);
        check("abort_state", 32'(dbg_state), 32'(S_DATA));
        beat(1'b0, f[14], 0);
        check("abort_one_cycle", 32'(abort), 32'd0);
        for (int i = 2; i < 16; i++) beat(1'b0, f[15-i], 0);
        wait_drain();
        check("abort_count", 32'(abort_seen - a0), 32'd1);
        check("abort_err_cnt", 32'(err_cnt), 32'd2);

        // Random frames with gaps and random m_ready against the model.
        rdy_mode = 2;
        for (int k = 0; k < 300; k++) begin
            d = DW'($urandom);
            f = make_frame(d);
            if ($urandom_range(0, 4) == 0) f = f ^ (16'h0001 << $urandom_range(0, 15));
            push_exp(f[15:4], gf2_rem(f) == 4'h0);
            send_frame(f, 2);
        end
        wait_drain();
        check("random_abort_none", 32'(abort_seen - a0), 32'd1);

        // Drive error count into saturation.
        rdy_mode = 1;
        guard = 0;
        while ((exp_err != 8'hFF || guard < 3) && guard < 400) begin
            if (exp_err == 8'hFF) guard++;
            d = DW'($urandom);
            f = make_frame(d) ^ 16'h0001;
            push_exp(d, 1'b0);
            send_frame(f, 0);
            if (exp_err != 8'hFF) guard = 0;
        end
        wait_drain();
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Asynchronous reset in S_CRC.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        f = 16'h0013;
        for (int i = 0; i < 14; i++) beat(i == 0, f[15-i], 0);
        check("pre_reset_state_crc", 32'(dbg_state), 32'(S_CRC));
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_in_crc");
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_err = '0;

        // Asynchronous reset in S_OUT (result dropped).
        send_frame(16'h0013, 0);
        check("pre_reset_m_valid", 32'(m_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_in_out");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean frame after reset.
        rdy_mode = 1;
        @(posedge clk);
        #1;
        push_exp(12'h000, 1'b1);
        send_frame(16'h0000, 0);
        wait_drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
